// File: rtl/id_ex_register.sv
// ID/EX pipeline register with flush/stall control, a saturating bubble counter
// and a sticky flag that catches sign-extended immediates whose upper half is malformed.
module id_ex_register #(
  parameter int unsigned CTRL_W = 12,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              Stall,
  input  logic              ID_Valid,
  input  logic [31:0]       ID_PCPlus4,
  input  logic [31:0]       ID_ReadData1,
  input  logic [31:0]       ID_ReadData2,
  input  logic [31:0]       ID_SignExtImm,
  input  logic [4:0]        ID_Rs,
  input  logic [4:0]        ID_Rt,
  input  logic [4:0]        ID_Rd,
  input  logic [CTRL_W-1:0] ID_Ctrl,
  output logic [31:0]       EX_PCPlus4,
  output logic [31:0]       EX_ReadData1,
  output logic [31:0]       EX_ReadData2,
  output logic [31:0]       EX_SignExtImm,
  output logic [4:0]        EX_Rs,
  output logic [4:0]        EX_Rt,
  output logic [4:0]        EX_Rd,
  output logic [CTRL_W-1:0] EX_Ctrl,
  output logic              EX_Valid,
  output logic [CNT_W-1:0]  BubbleCount,
  output logic              ImmError
);

  logic             load;
  logic             bubble;
  logic             imm_bad;
  logic             cnt_sat;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    load     = !Flush && !Stall;
    // A flush always inserts a bubble; a normal load of an invalid entry does too.
    bubble   = Flush || (load && !ID_Valid);
    imm_bad  = load && ID_Valid && (ID_SignExtImm[31:16] != {16{ID_SignExtImm[15]}});
    cnt_sat  = (BubbleCount == {CNT_W{1'b1}});
    cnt_next = cnt_sat ? BubbleCount : BubbleCount + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      EX_PCPlus4    <= '0;
      EX_ReadData1  <= '0;
      EX_ReadData2  <= '0;
      EX_SignExtImm <= '0;
      EX_Rs         <= '0;
      EX_Rt         <= '0;
      EX_Rd         <= '0;
      EX_Ctrl       <= '0;
      EX_Valid      <= 1'b0;
      BubbleCount   <= '0;
      ImmError      <= 1'b0;
    end else begin
      if (Flush) begin
        EX_PCPlus4    <= '0;
        EX_ReadData1  <= '0;
        EX_ReadData2  <= '0;
        EX_SignExtImm <= '0;
        EX_Rs         <= '0;
        EX_Rt         <= '0;
        EX_Rd         <= '0;
        EX_Ctrl       <= '0;
        EX_Valid      <= 1'b0;
      end else if (load) begin
        EX_PCPlus4    <= ID_PCPlus4;
        EX_ReadData1  <= ID_ReadData1;
        EX_ReadData2  <= ID_ReadData2;
        EX_SignExtImm <= ID_SignExtImm;
        EX_Rs         <= ID_Rs;
        EX_Rt         <= ID_Rt;
        EX_Rd         <= ID_Rd;
        EX_Ctrl       <= ID_Ctrl;
        EX_Valid      <= ID_Valid;
      end
      if (bubble) begin
        BubbleCount <= cnt_next;
      end
      if (imm_bad) begin
        ImmError <= 1'b1;
      end
    end
  end

endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 SHALL have parameter CTRL_W, default 12: width of the decoded control bundle carried from ID to EX.
REQ-002 SHALL have parameter CNT_W, default 16: width of the bubble counter.
REQ-003 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port Flush, input, 1, which converts the next-loaded entry into a bubble.
REQ-006 SHALL have port Stall, input, 1, which holds the current contents.
REQ-007 SHALL have port ID_Valid, input, 1, which marks the ID-stage entry as a real instruction.
REQ-008 SHALL have ports ID_PCPlus4, ID_ReadData1 and ID_ReadData2, input, 32 each: PC+4 and the two register-file read values.
REQ-009 SHALL have port ID_SignExtImm, input, 32: the sign-extended 16-bit immediate from the sign-extension unit.
REQ-010 SHALL have ports ID_Rs, ID_Rt and ID_Rd, input, 5 each: register specifiers.
REQ-011 SHALL have port ID_Ctrl, input, CTRL_W: decoded control signals.
REQ-012 SHALL have outputs EX_PCPlus4, EX_ReadData1, EX_ReadData2 and EX_SignExtImm (32 each), EX_Rs, EX_Rt and EX_Rd (5 each), EX_Ctrl (CTRL_W) and EX_Valid (1): the registered copies of the matching ID inputs.
REQ-013 SHALL have output BubbleCount, CNT_W: saturating count of bubbles issued into EX.
REQ-014 SHALL have output ImmError, 1: sticky flag for a malformed sign-extended immediate.

Function
REQ-015 SHALL apply per-edge priority Reset > Flush > Stall > normal load.
REQ-016 SHALL, on normal load (Flush=0, Stall=0), capture every ID_* input into its EX_* counterpart with exactly 1-cycle latency and no combinational input-to-output path.
REQ-017 SHALL, on Stall=1 with Flush=0, hold all EX_* outputs, BubbleCount and ImmError unchanged.
REQ-018 SHALL, on Flush=1, load all EX_* data, specifier and control outputs with 0 and EX_Valid with 0, regardless of Stall.
REQ-019 SHALL count a bubble on any non-stalled, non-reset edge that loads EX_Valid=0, whether from Flush=1 or from ID_Valid=0.
REQ-020 SHALL increment BubbleCount by 1 per counted bubble, saturating at 2^CNT_W-1 with no wrap.
REQ-021 SHALL check each entry captured on normal load with ID_Valid=1: if ID_SignExtImm[31:16] is not 16 copies of ID_SignExtImm[15], ImmError is set on that edge.
REQ-022 SHALL keep ImmError set once set until Reset; the entry is still passed through unmodified.
REQ-023 SHALL NOT check the immediate on a flushed, stalled or invalid entry.
REQ-024 SHALL, when Flush and Stall are both 1, flush with the bubble counted, because flush overrides stall.
REQ-025 SHALL NOT let a held entry that is stalled for N cycles re-check the immediate or count again.

Reset
REQ-026 SHALL, on Reset=1 at a rising edge, clear all EX_* outputs to 0, EX_Valid to 0, BubbleCount to 0 and ImmError to 0, overriding Flush and Stall.
REQ-027 SHALL NOT count the reset edge as a bubble; the first post-reset edge loads normally.
REQ-028 SHALL, on Reset asserted mid-stall, discard the held entry.

Verification
REQ-029 SHALL pass: load with ID_SignExtImm=0xFFFF8004, ID_Rt=5, ID_Valid=1 -> next cycle EX_SignExtImm=0xFFFF8004, EX_Rt=5, EX_Valid=1, ImmError=0.
REQ-030 SHALL pass: load entry A, then Stall=1 for 3 cycles while ID inputs change -> EX_* equal A for all 3 cycles and BubbleCount unchanged.
REQ-031 SHALL pass: Flush=1 and Stall=1 on the same edge with BubbleCount=4 -> all EX_* = 0, EX_Valid=0, BubbleCount=5.
REQ-032 SHALL pass: valid load with ID_SignExtImm=0x00018000 -> ImmError=1 next cycle and it stays 1 across 10 normal loads; after Reset it is 0.
REQ-033 SHALL pass: with CNT_W=4, 20 consecutive edges with ID_Valid=0 -> BubbleCount reaches 15 and holds there.
REQ-034 SHALL pass: Reset=1 together with Flush=1 and valid inputs -> all outputs 0 and BubbleCount=0, not 1.
